// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - WIDTH x DEPTH storage, synchronous write, asynchronous read.
module fifo_sync_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - Parametrised synchronous FIFO with thresholds, sticky errors, flush and FWFT option.
module fifo_sync #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;
    localparam int AW       = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of two and at least 2");
    end

    logic [CW-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, count_nx, count_q;
    logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic             pop_ok, push_ok;
    logic [WIDTH-1:0] ram_rdata;

    assign pop_ok  = i_pop & ~empty_q;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push_ok = i_push & (~full_q | pop_ok);

    always_comb begin
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        if (i_clr) begin
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
        end else begin
            if (push_ok) wr_ptr_nx = wr_ptr + CW'(1);
            if (pop_ok)  rd_ptr_nx = rd_ptr + CW'(1);
        end
        count_nx = wr_ptr_nx - rd_ptr_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (i_en) begin
            wr_ptr  <= wr_ptr_nx;
            rd_ptr  <= rd_ptr_nx;
            count_q <= count_nx;
            full_q  <= (count_nx == CW'(DEPTH));
            empty_q <= (count_nx == '0);
            af_q    <= (count_nx >= CW'(AF_LEVEL));
            ae_q    <= (count_nx <= CW'(AE_LEVEL));
            if (i_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (i_push && !push_ok) ovf_q <= 1'b1;
                if (i_pop && !pop_ok)   unf_q <= 1'b1;
            end
        end
    end

    fifo_sync_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (i_clk),
        .we   (i_en & ~i_clr & push_ok),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(i_data),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(ram_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign o_data  = ram_rdata;
        assign o_valid = ~empty_q;
    end else begin : g_registered
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (i_en) begin
                if (i_clr) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= pop_ok;
                    if (pop_ok) rdata_q <= ram_rdata;
                end
            end
        end

        assign o_data  = rdata_q;
        assign o_valid = rvalid_q;
    end

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_count        = count_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

`ifdef FORMAL
    a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
        count_q <= CW'(DEPTH));
    a_full_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        !(full_q && empty_q));
    a_hold_when_disabled: assert property (@(posedge i_clk) disable iff (i_rst)
        !i_en |=> ($stable(wr_ptr) && $stable(rd_ptr)));
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - Self-checking bench for fifo_sync, registered and FWFT instances against a queue model.
module tb_fifo_sync;

    localparam int W = 8;
    localparam int D = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst, en, clr, push, pop;
    logic [W-1:0] din;

    logic [W-1:0]  data_r, data_f;
    logic          valid_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic          valid_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [CW-1:0] count_r, count_f;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    bit           m_ovf, m_unf, m_valid;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    fifo_sync #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_push(push), .i_data(din),
        .i_pop(pop), .o_data(data_r), .o_valid(valid_r), .o_full(full_r), .o_empty(empty_r),
        .o_count(count_r), .o_almost_full(af_r), .o_almost_empty(ae_r),
        .o_overflow(ovf_r), .o_underflow(unf_r)
    );

    fifo_sync #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_f (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .i_push(push), .i_data(din),
        .i_pop(pop), .o_data(data_f), .o_valid(valid_f), .o_full(full_f), .o_empty(empty_f),
        .o_count(count_f), .o_almost_full(af_f), .o_almost_empty(ae_f),
        .o_overflow(ovf_f), .o_underflow(unf_f)
    );

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_valid = 0;
        m_data = '0;
    endtask

    // Drive one cycle, advance the reference model, and return 1ns after the edge.
    task automatic cyc(input bit e, input bit c, input bit pu, input bit po, input logic [W-1:0] d);
        bit pop_ok, push_ok;
        en = e; clr = c; push = pu; pop = po; din = d;
        if (e) begin
            if (c) begin
                model_reset();
            end else begin
                pop_ok  = po && q.size() > 0;
                push_ok = pu && (q.size() < D || pop_ok);
                if (po && !pop_ok) m_unf = 1;
                if (pu && !push_ok) m_ovf = 1;
                m_valid = pop_ok;
                if (pop_ok) m_data = q.pop_front();
                if (push_ok) q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        en = 0; clr = 0; push = 0; pop = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; clr = 0; push = 0; pop = 0; din = '0;
        model_reset();
        @(posedge clk); #1;
        n_vec++;
        if ({count_r, empty_r, full_r, ae_r, af_r, valid_r, ovf_r, unf_r, data_r} !== {3'd0, 7'b1010000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b valid=%b ovf=%b unf=%b data=%h, required count=0 empty=1 full=0 ae=1 af=0 valid=0 ovf=0 unf=0 data=00",
                     count_r, empty_r, full_r, ae_r, af_r, valid_r, ovf_r, unf_r, data_r);
        end
        n_vec++;
        if ({valid_f, empty_f} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_fwft: valid=%b empty=%b, required 0 1", valid_f, empty_f);
        end
        rst = 0;
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, vals[i]);
        n_vec++;
        if ({full_r, count_r, af_r} !== {1'b1, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL fill_full: full=%b count=%0d af=%b, required 1 4 1", full_r, count_r, af_r);
        end
        n_vec++;
        if ({valid_f, data_f} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL fill_fwft_head: valid=%b data=%h, required 1 11", valid_f, data_f);
        end
        cyc(1, 0, 1, 0, 8'h55);
        n_vec++;
        if ({ovf_r, count_r} !== {1'b1, 3'd4}) begin
            n_err++;
            $display("FAIL overflow: ovf=%b count=%0d, required 1 4", ovf_r, count_r);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1, 8'h00);
            n_vec++;
            if ({valid_r, data_r} !== {1'b1, vals[i]}) begin
                n_err++;
                $display("FAIL drain_%0d: valid=%b data=%h, required 1 %h", i, valid_r, data_r, vals[i]);
            end
        end
        cyc(1, 0, 0, 0, 8'h00);
        n_vec++;
        if ({valid_r, empty_r, data_r} !== {1'b0, 1'b1, 8'h44}) begin
            n_err++;
            $display("FAIL drain_end: valid=%b empty=%b data=%h, required 0 1 44", valid_r, empty_r, data_r);
        end
    endtask

    task automatic test_underflow_clear();
        cyc(1, 0, 0, 1, 8'h00);
        n_vec++;
        if ({unf_r, valid_r, ovf_r} !== 3'b101) begin
            n_err++;
            $display("FAIL underflow: unf=%b valid=%b ovf=%b, required 1 0 1", unf_r, valid_r, ovf_r);
        end
        cyc(1, 1, 0, 0, 8'h00);
        n_vec++;
        if ({unf_r, ovf_r, count_r, empty_r} !== {2'b00, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL clear: unf=%b ovf=%b count=%0d empty=%b, required 0 0 0 1", unf_r, ovf_r, count_r, empty_r);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, 0, W'(i));
            n_vec++;
            if ({count_r, full_r, empty_r} !== {3'd1, 2'b00}) begin
                n_err++;
                $display("FAIL wrap_push_%0d: count=%0d full=%b empty=%b, required 1 0 0", i, count_r, full_r, empty_r);
            end
            cyc(1, 0, 0, 1, 8'h00);
            n_vec++;
            if ({valid_r, data_r, count_r, empty_r, full_r} !== {1'b1, W'(i), 3'd0, 2'b10}) begin
                n_err++;
                $display("FAIL wrap_pop_%0d: valid=%b data=%h count=%0d empty=%b full=%b, required 1 %h 0 1 0",
                         i, valid_r, data_r, count_r, empty_r, full_r, W'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp [4] = '{8'h02, 8'h03, 8'h04, 8'hAA};
        for (int i = 1; i <= 4; i++) cyc(1, 0, 1, 0, W'(i));
        cyc(1, 0, 1, 1, 8'hAA);
        n_vec++;
        if ({count_r, ovf_r, valid_r, data_r} !== {3'd4, 1'b0, 1'b1, 8'h01}) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%b valid=%b data=%h, required 4 0 1 01", count_r, ovf_r, valid_r, data_r);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 1, 8'h00);
            n_vec++;
            if (data_r !== exp[i]) begin
                n_err++;
                $display("FAIL full_push_pop_order_%0d: data=%h, required %h", i, data_r, exp[i]);
            end
        end
        cyc(1, 0, 1, 1, 8'h77);
        n_vec++;
        if ({count_r, unf_r, valid_r} !== {3'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL empty_push_pop: count=%0d unf=%b valid=%b, required 1 1 0", count_r, unf_r, valid_r);
        end
    endtask

    task automatic test_fwft();
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 8'h5A);
        n_vec++;
        if ({valid_f, data_f, valid_r} !== {1'b1, 8'h5A, 1'b0}) begin
            n_err++;
            $display("FAIL fwft_fallthrough: valid=%b data=%h reg_valid=%b, required 1 5a 0", valid_f, data_f, valid_r);
        end
        cyc(1, 0, 0, 1, 8'h00);
        n_vec++;
        if ({valid_f, valid_r, data_r} !== {2'b01, 8'h5A}) begin
            n_err++;
            $display("FAIL fwft_ack: fwft_valid=%b reg_valid=%b reg_data=%h, required 0 1 5a", valid_f, valid_r, data_r);
        end
    endtask

    task automatic test_thresholds_reset();
        cyc(1, 1, 0, 0, 8'h00);
        for (int n = 1; n <= 4; n++) begin
            cyc(1, 0, 1, 0, W'(8'hC0 + n));
            n_vec++;
            if ({af_r, ae_r} !== {n >= 3, n <= 1}) begin
                n_err++;
                $display("FAIL threshold_%0d: af=%b ae=%b, required %b %b", n, af_r, ae_r, n >= 3, n <= 1);
            end
        end
        cyc(0, 1, 1, 1, 8'hEE);
        n_vec++;
        if ({count_r, valid_r, ovf_r, unf_r} !== {3'd4, 3'b000}) begin
            n_err++;
            $display("FAIL disabled_hold: count=%0d valid=%b ovf=%b unf=%b, required 4 0 0 0", count_r, valid_r, ovf_r, unf_r);
        end
        cyc(1, 0, 1, 0, 8'hEE);
        en = 1; pop = 1;
        #3 rst = 1;
        #1;
        n_vec++;
        if ({count_r, ovf_r, unf_r, valid_r, empty_r, af_r, ae_r} !== {3'd0, 3'b000, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: count=%0d ovf=%b unf=%b valid=%b empty=%b af=%b ae=%b, required 0 0 0 0 1 0 1",
                     count_r, ovf_r, unf_r, valid_r, empty_r, af_r, ae_r);
        end
        @(posedge clk); #1;
        en = 0; pop = 0; rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, W'($urandom));
            n_vec++;
            if ({count_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r, valid_r, data_r} !==
                {CW'(q.size()), q.size() == D, q.size() == 0, q.size() >= 3, q.size() <= 1, m_ovf, m_unf, m_valid, m_data}) begin
                n_err++;
                $display("FAIL random_%0d: count=%0d full=%b empty=%b af=%b ae=%b ovf=%b unf=%b valid=%b data=%h, required %0d %b %b %b %b %b %b %b %h",
                         i, count_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r, valid_r, data_r,
                         q.size(), q.size() == D, q.size() == 0, q.size() >= 3, q.size() <= 1, m_ovf, m_unf, m_valid, m_data);
            end
            n_vec++;
            if (valid_f !== (q.size() > 0) || (q.size() > 0 && data_f !== q[0]) || count_f !== CW'(q.size())) begin
                n_err++;
                $display("FAIL random_fwft_%0d: valid=%b data=%h count=%0d, required valid=%b head=%h count=%0d",
                         i, valid_f, data_f, count_f, q.size() > 0, (q.size() > 0) ? q[0] : 8'h00, q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow_clear();
        test_wrap();
        test_back_to_back();
        test_fwft();
        test_thresholds_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Parametrised synchronous FIFO; next generation of the CPU's byte FIFO. Buffers words between producers and consumers in the Forth CPU, e.g. UART RX/TX and data-stack spill.
- Adds full/empty protection, an occupancy count and programmable almost-thresholds.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a compile-time read mode (registered read or first-word-fall-through).

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 256, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-1, o_almost_full asserted when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, o_almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = registered read (data one cycle after pop); 1 = first-word-fall-through.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_en  in  1  global enable; when 0, no state changes.
- i_clr  in  1  synchronous flush.
- i_push  in  1  write request.
- i_data  in  WIDTH  write data.
- i_pop  in  1  read request.
- o_data  out  WIDTH  read data.
- o_valid  out  1  o_data valid (see modes).
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- o_almost_full  out  1  count >= AF_LEVEL.
- o_almost_empty  out  1  count <= AE_LEVEL.
- o_overflow  out  1  sticky: a push was rejected.
- o_underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async, any time including mid-operation):
  - Pointers, count, o_data, o_valid, o_overflow and o_underflow go to 0.
  - o_empty=1, o_full=0, o_almost_empty=1.
  - o_almost_full=0 unless AF_LEVEL==0 (disallowed).
  - Memory contents are don't-care.
- Pointers: rd_ptr and wr_ptr are each $clog2(DEPTH)+1 bits. The MSB is the wrap bit and the index is the low bits, so wrap-around is natural modulo 2*DEPTH. Occupancy is count = wr_ptr - rd_ptr.
- Flags (o_full, o_empty, o_count, o_almost_*) are registered and update in the same edge as the pointer change, so they are valid the cycle after the push/pop edge.
- i_en=0: push, pop and clr are ignored. All outputs hold; no error flags set.
- Priority with i_en=1: i_clr > push/pop.
- i_clr=1:
  - Pointers and count go to 0; o_overflow and o_underflow go to 0.
  - o_valid goes to 0; o_data goes to 0 when FWFT=0.
  - Concurrent push/pop are discarded.
- Push acceptance: i_push & (~o_full | pop_accepted).
  - Push on full is accepted if a pop is accepted in the same cycle; count stays DEPTH.
  - Otherwise a push on full is dropped, memory and pointers are unchanged, and o_overflow is set to 1.
- Pop acceptance: i_pop & ~o_empty.
  - Pop on empty is rejected even if a push arrives in the same cycle; the push is still accepted.
  - A rejected pop sets o_underflow=1.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Unlike the predecessor, push/pop are level-qualified per cycle with no edge detection. Holding i_push high for N cycles writes N words (subject to full).
- FWFT=0 (registered read):
  - On an accepted pop, o_data <= mem[rd_idx] and o_valid <= 1 for exactly one cycle.
  - o_valid=0 in any cycle following no accepted pop; o_data holds its last value.
  - Latency pop->data is 1 cycle.
- FWFT=1 (first-word-fall-through):
  - o_data = mem[rd_idx] (asynchronous memory read) and o_valid = ~o_empty.
  - i_pop acts as acknowledge of the current head.
  - A word pushed into an empty FIFO appears on o_data the cycle after its push edge (when o_empty falls).
- Error flags stay high until i_clr or i_rst.
- Any legal parameter combination must elaborate. DEPTH not a power of two is a compile-time error (generate-time check).

Decomposition:
- No shared package needed. Mode constants (FWFT_OFF=0, FWFT_ON=1) live as localparams in fifo_sync.
- One sub-module is natural: fifo_sync_ram (WIDTH x DEPTH, one synchronous write port and one asynchronous read port).
  - fifo_sync registers the read output for FWFT=0.
  - Isolating the RAM allows later substitution by an inferred block RAM.
- Formal properties are kept under the FORMAL define:
  - count <= DEPTH.
  - o_full and o_empty are never both 1.
  - Pointers are stable when i_en=0.

Test Plan:
- Fill/drain, DEPTH=4, FWFT=0: push 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: o_full=1, o_count=4. A 5th push of 0x55 sets o_overflow=1 and count stays 4.
  - Then 4 pops return 0x11..0x44, each with a 1-cycle o_valid pulse. Afterwards o_empty=1.
- Underflow and clear: pop on empty.
  - Required: o_underflow=1, o_valid stays 0.
  - Then assert i_clr for 1 cycle. Required: both error flags return to 0 and count=0.
- Wrap-around, DEPTH=4: 10 iterations of push then pop.
  - Required: data 0..9 returned in order, pointer wrap causes no false full/empty, count never exceeds 1.
- Simultaneous push+pop:
  - At count=4 (full), push 0xAA with pop. Required: accepted, count=4, no overflow, and 0xAA emerges after the 3 older words plus the popped head.
  - At count=0, push+pop. Required: count=1, o_underflow=1.
- FWFT=1: push 0x5A into an empty FIFO.
  - Required: o_valid=1 and o_data=0x5A the next cycle without a pop. A pop then drops o_valid to 0.
- Thresholds and reset, AF_LEVEL=3, AE_LEVEL=1, DEPTH=4:
  - o_almost_full rises at count 3; o_almost_empty falls at count 2.
  - Asserting i_rst mid-burst immediately zeroes count, errors and o_valid, and sets o_empty=1.
